// File: rtl/pkt_rx_assembler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pkt_rx_assembler_if : beat-stream input, output queue and status counters
// Revision 1.0
// ----------------------------------------------------------------------------
interface pkt_rx_assembler_if #(
  parameter int PKT_WIDTH  = 8,
  parameter int PKT_LENGTH = 4,
  parameter int DATA_WIDTH = PKT_WIDTH * PKT_LENGTH,
  parameter int CNT_WIDTH  = 16
);
  logic [1:0]            link_state;
  logic [PKT_WIDTH-1:0]  pkt;
  logic                  pkt_sop;
  logic                  pkt_eop;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]  good_cnt;
  logic [CNT_WIDTH-1:0]  err_cnt;
  logic [CNT_WIDTH-1:0]  drop_cnt;

  // master: link controller / consumer side, slave: the assembler
  modport master (
    output link_state, pkt, pkt_sop, pkt_eop, out_ready,
    input  out_valid, out_data, good_cnt, err_cnt, drop_cnt
  );
  modport slave (
    input  link_state, pkt, pkt_sop, pkt_eop, out_ready,
    output out_valid, out_data, good_cnt, err_cnt, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pkt_rx_assembler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pkt_rx_assembler : frames byte beats into words, 2-entry output queue
// Revision 1.0
// ----------------------------------------------------------------------------
module pkt_rx_assembler #(
  parameter int PKT_WIDTH  = 8,
  parameter int PKT_LENGTH = 4,
  parameter int DATA_WIDTH = PKT_WIDTH * PKT_LENGTH,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pkt_rx_assembler_if.slave bus
);
  localparam int CW = $clog2(PKT_LENGTH + 1) + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [DATA_WIDTH-1:0] q0_q, q0_d, q1_q, q1_d;
  logic [1:0]            qcnt_q, qcnt_d;
  logic                  valid_q, valid_d;
  logic [CNT_WIDTH-1:0]  good_q, good_d, err_q, err_d, drop_q, drop_d;

  logic link_up, start, err_evt, push, pop, push_ok, drop_evt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign link_up = (bus.link_state == 2'b11);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    start   = 1'b0;
    err_evt = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.pkt_sop && bus.pkt_eop) err_evt = 1'b1;
        else if (bus.pkt_sop && link_up) start = 1'b1;
      end
      ST_RECV: begin
        if (!link_up) begin
          err_evt = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.pkt_sop) begin
          // abort current frame; this sop begins the next one
          err_evt = 1'b1;
          if (bus.pkt_eop) state_d = ST_IDLE;
          else             start   = 1'b1;
        end else if (bus.pkt_eop) begin
          if (cnt_q == CW'(PKT_LENGTH)) push    = 1'b1;
          else                          err_evt = 1'b1;
          state_d = ST_IDLE;
        end else begin
          for (int k = 0; k < PKT_LENGTH; k++) begin
            if (cnt_q == CW'(k)) buf_d[k*PKT_WIDTH +: PKT_WIDTH] = bus.pkt;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(PKT_LENGTH)) begin
            err_evt = 1'b1;
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (!link_up) state_d = ST_IDLE;
        else if (bus.pkt_sop && bus.pkt_eop) begin
          err_evt = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.pkt_sop) start   = 1'b1;
        else if (bus.pkt_eop)     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      buf_d                = '0;
      buf_d[PKT_WIDTH-1:0] = bus.pkt;
      cnt_d                = CW'(1);
      state_d              = ST_RECV;
    end
  end

  // Queue: entry 0 is the head and drives out_data directly
  always_comb begin
    pop      = valid_q && bus.out_ready;
    push_ok  = push && ((qcnt_q != 2'd2) || pop);
    drop_evt = push && !push_ok;
    q0_d     = q0_q;
    q1_d     = q1_q;
    qcnt_d   = qcnt_q;
    unique case ({push_ok, pop})
      2'b01: begin
        q0_d   = q1_q;
        qcnt_d = qcnt_q - 2'd1;
      end
      2'b10: begin
        if (qcnt_q == 2'd0) q0_d = buf_q;
        else                q1_d = buf_q;
        qcnt_d = qcnt_q + 2'd1;
      end
      2'b11: begin
        if (qcnt_q == 2'd1) q0_d = buf_q;
        else begin
          q0_d = q1_q;
          q1_d = buf_q;
        end
      end
      default: ;
    endcase
    valid_d = (qcnt_d != 2'd0);
    good_d  = sat_inc(good_q, push_ok);
    err_d   = sat_inc(err_q, err_evt);
    drop_d  = sat_inc(drop_q, drop_evt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      q0_q    <= '0;
      q1_q    <= '0;
      qcnt_q  <= 2'd0;
      valid_q <= 1'b0;
      good_q  <= '0;
      err_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      qcnt_q  <= qcnt_d;
      valid_q <= valid_d;
      good_q  <= good_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = q0_q;
  assign bus.good_cnt  = good_q;
  assign bus.err_cnt   = err_q;
  assign bus.drop_cnt  = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_pkt_rx_assembler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pkt_rx_assembler : vector-table bench for pkt_rx_assembler
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_pkt_rx_assembler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_rx_assembler_if #(.PKT_WIDTH(8), .PKT_LENGTH(4), .CNT_WIDTH(16)) bus_m ();
  pkt_rx_assembler_if #(.PKT_WIDTH(8), .PKT_LENGTH(4), .CNT_WIDTH(4))  bus_s ();

  pkt_rx_assembler #(.PKT_WIDTH(8), .PKT_LENGTH(4), .CNT_WIDTH(16)) dut (
    .clk (clk), .rst (rst), .bus (bus_m));
  pkt_rx_assembler #(.PKT_WIDTH(8), .PKT_LENGTH(4), .CNT_WIDTH(4)) dut_sat (
    .clk (clk), .rst (rst), .bus (bus_s));

  // The narrow-counter instance sees the same stimulus
  assign bus_s.link_state = bus_m.link_state;
  assign bus_s.pkt        = bus_m.pkt;
  assign bus_s.pkt_sop    = bus_m.pkt_sop;
  assign bus_s.pkt_eop    = bus_m.pkt_eop;
  assign bus_s.out_ready  = bus_m.out_ready;

  typedef struct {
    logic [1:0]  link;
    logic [7:0]  pkt;
    logic        sop, eop, ready;
    logic        ev;
    logic [31:0] ed;
    int          eg, ee, edr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic [1:0] l, input logic [7:0] p, input logic s, e, r,
                     input logic ev, input logic [31:0] ed, input int eg, ee, edr);
    vec_t v;
    v.link = l; v.pkt = p; v.sop = s; v.eop = e; v.ready = r;
    v.ev = ev; v.ed = ed; v.eg = eg; v.ee = ee; v.edr = edr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] ed,
                           input int eg, input int ee, input int edr);
    chk({tag, " out_valid"}, {31'd0, bus_m.out_valid}, {31'd0, ev});
    if (ev) chk({tag, " out_data"}, bus_m.out_data, ed);
    chk({tag, " good_cnt"}, {16'd0, bus_m.good_cnt}, eg);
    chk({tag, " err_cnt"},  {16'd0, bus_m.err_cnt},  ee);
    chk({tag, " drop_cnt"}, {16'd0, bus_m.drop_cnt}, edr);
  endtask

  task automatic drive(input logic [1:0] l, input logic [7:0] p, input logic s, e, r);
    @(negedge clk);
    bus_m.link_state = l;
    bus_m.pkt        = p;
    bus_m.pkt_sop    = s;
    bus_m.pkt_eop    = e;
    bus_m.out_ready  = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_m.link_state = 2'b11;
    bus_m.pkt        = '0;
    bus_m.pkt_sop    = 1'b0;
    bus_m.pkt_eop    = 1'b0;
    bus_m.out_ready  = 1'b1;

    // good frame
    add(3,'h11,1,0,1, 0,0,0,0,0); add(3,'h22,0,0,1, 0,0,0,0,0);
    add(3,'h33,0,0,1, 0,0,0,0,0); add(3,'h44,0,0,1, 0,0,0,0,0);
    add(3,'h00,0,1,1, 1,'h44332211,1,0,0);
    add(3,'h00,0,0,1, 0,0,1,0,0);
    // short frame, then a good frame held one cycle by out_ready=0
    add(3,'hAA,1,0,1, 0,0,1,0,0); add(3,'hBB,0,0,1, 0,0,1,0,0);
    add(3,'h00,0,1,1, 0,0,1,1,0);
    add(3,'h01,1,0,1, 0,0,1,1,0); add(3,'h02,0,0,1, 0,0,1,1,0);
    add(3,'h03,0,0,1, 0,0,1,1,0); add(3,'h04,0,0,1, 0,0,1,1,0);
    add(3,'h00,0,1,0, 1,'h04030201,2,1,0);
    add(3,'h00,0,0,0, 1,'h04030201,2,1,0);
    add(3,'h00,0,0,1, 0,0,2,1,0);
    // long frame: error on the fifth beat, then discard until eop
    add(3,'h10,1,0,1, 0,0,2,1,0); add(3,'h20,0,0,1, 0,0,2,1,0);
    add(3,'h30,0,0,1, 0,0,2,1,0); add(3,'h40,0,0,1, 0,0,2,1,0);
    add(3,'h50,0,0,1, 0,0,2,2,0); add(3,'h60,0,0,1, 0,0,2,2,0);
    add(3,'h00,0,1,1, 0,0,2,2,0);
    add(3,'hA1,1,0,1, 0,0,2,2,0); add(3,'hA2,0,0,1, 0,0,2,2,0);
    add(3,'hA3,0,0,1, 0,0,2,2,0); add(3,'hA4,0,0,1, 0,0,2,2,0);
    add(3,'h00,0,1,1, 1,'hA4A3A2A1,3,2,0);
    add(3,'h00,0,0,1, 0,0,3,2,0);
    // restart at beat 2
    add(3,'h01,1,0,1, 0,0,3,2,0); add(3,'h02,0,0,1, 0,0,3,2,0);
    add(3,'hB0,1,0,1, 0,0,3,3,0); add(3,'hB1,0,0,1, 0,0,3,3,0);
    add(3,'hB2,0,0,1, 0,0,3,3,0); add(3,'hB3,0,0,1, 0,0,3,3,0);
    add(3,'h00,0,1,1, 1,'hB3B2B1B0,4,3,0);
    add(3,'h00,0,0,1, 0,0,4,3,0);
    // link drop mid-frame, then sop while link down is ignored
    add(3,'hC0,1,0,1, 0,0,4,3,0); add(3,'hC1,0,0,1, 0,0,4,3,0);
    add(1,'hC2,0,0,1, 0,0,4,4,0); add(1,'h00,0,1,1, 0,0,4,4,0);
    add(1,'h55,1,0,1, 0,0,4,4,0); add(3,'h66,0,0,1, 0,0,4,4,0);
    add(3,'h00,0,1,1, 0,0,4,4,0);
    // backpressure: three frames, third dropped
    add(3,'h11,1,0,0, 0,0,4,4,0); add(3,'h12,0,0,0, 0,0,4,4,0);
    add(3,'h13,0,0,0, 0,0,4,4,0); add(3,'h14,0,0,0, 0,0,4,4,0);
    add(3,'h00,0,1,0, 1,'h14131211,5,4,0); add(3,'h00,0,0,0, 1,'h14131211,5,4,0);
    add(3,'h21,1,0,0, 1,'h14131211,5,4,0); add(3,'h22,0,0,0, 1,'h14131211,5,4,0);
    add(3,'h23,0,0,0, 1,'h14131211,5,4,0); add(3,'h24,0,0,0, 1,'h14131211,5,4,0);
    add(3,'h00,0,1,0, 1,'h14131211,6,4,0); add(3,'h00,0,0,0, 1,'h14131211,6,4,0);
    add(3,'h31,1,0,0, 1,'h14131211,6,4,0); add(3,'h32,0,0,0, 1,'h14131211,6,4,0);
    add(3,'h33,0,0,0, 1,'h14131211,6,4,0); add(3,'h34,0,0,0, 1,'h14131211,6,4,0);
    add(3,'h00,0,1,0, 1,'h14131211,6,4,1); add(3,'h00,0,0,0, 1,'h14131211,6,4,1);
    add(3,'h00,0,0,1, 1,'h24232221,6,4,1); add(3,'h00,0,0,1, 0,0,6,4,1);
    // sop and eop together in IDLE
    add(3,'h77,1,1,1, 0,0,6,5,1);

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 32'h0, 0, 0, 0);
    chk("reset out_data", bus_m.out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].link, vecs[i].pkt, vecs[i].sop, vecs[i].eop, vecs[i].ready);
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed,
                vecs[i].eg, vecs[i].ee, vecs[i].edr);
    end

    // Reset mid-frame with a word still queued
    drive(3, 8'h01, 1, 0, 0); drive(3, 8'h02, 0, 0, 0);
    drive(3, 8'h03, 0, 0, 0); drive(3, 8'h04, 0, 0, 0);
    drive(3, 8'h00, 0, 1, 0);
    check_all("pre-rst", 1'b1, 32'h04030201, 7, 5, 1);
    drive(3, 8'h05, 1, 0, 0);
    drive(3, 8'h06, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_all("async rst", 1'b0, 32'h0, 0, 0, 0);
    chk("async rst out_data", bus_m.out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(3, 8'h07, 0, 0, 1); drive(3, 8'h08, 0, 0, 1);
    drive(3, 8'h00, 0, 1, 1);
    check_all("post-rst", 1'b0, 32'h0, 0, 0, 0);

    // Saturation: 17 errors into a 4-bit counter
    for (int i = 0; i < 17; i++) drive(3, 8'h00, 1, 1, 1);
    chk("main err_cnt 17", {16'd0, bus_m.err_cnt}, 32'd17);
    chk("sat err_cnt", {28'd0, bus_s.err_cnt}, 32'd15);
    chk("sat good_cnt", {28'd0, bus_s.good_cnt}, 32'd0);
    drive(3, 8'h00, 1, 1, 1);
    chk("sat err_cnt hold", {28'd0, bus_s.err_cnt}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
